// File: rtl/conv_stream_sat.sv
// Streaming strided 1-D convolution: F taps and X samples arrive over valid/ready,
// and each window dot product leaves a stall-able multiply/adder-tree pipeline rectified and saturated.
module conv_stream_sat #(
   parameter int DATA_WIDTH_X = 8,
   parameter int DATA_WIDTH_F = 8,
   parameter int X_SIZE       = 128,
   parameter int F_SIZE       = 32,
   parameter int STRIDE       = 1,
   parameter int OUT_WIDTH    = 16,
   parameter int RELU_EN      = 0,
   parameter int F_RELOAD     = 1
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           s_valid_f,
   output logic                           s_ready_f,
   input  logic signed [DATA_WIDTH_F-1:0] s_data_in_f,
   input  logic                           s_valid_x,
   output logic                           s_ready_x,
   input  logic signed [DATA_WIDTH_X-1:0] s_data_in_x,
   output logic                           m_valid_y,
   input  logic                           m_ready_y,
   output logic signed [OUT_WIDTH-1:0]    m_data_out_y,
   output logic                           m_sat_y,
   output logic                           m_last_y
);

   localparam int LOG_F = $clog2(F_SIZE);
   localparam int ACC   = DATA_WIDTH_X + DATA_WIDTH_F + LOG_F;
   localparam int XW    = $clog2(X_SIZE + 1);
   localparam int SW    = (STRIDE > 1) ? $clog2(STRIDE) : 1;

   logic                           f_loaded;
   logic [LOG_F-1:0]               f_cnt;
   logic [XW-1:0]                  x_cnt;
   logic [XW-1:0]                  x_nxt;
   logic [SW-1:0]                  s_cnt;
   logic signed [DATA_WIDTH_F-1:0] f_reg [F_SIZE];
   logic signed [DATA_WIDTH_X-1:0] win   [F_SIZE];
   // Heap-ordered adder tree: leaves F_SIZE..2*F_SIZE-1 hold products, node 1 is the full sum.
   logic signed [ACC-1:0]          tree  [1:2*F_SIZE-1];
   logic                           tok_v;
   logic                           tok_last;
   logic [LOG_F:0]                 pv;
   logic [LOG_F:0]                 pl;
   logic                           en;
   logic                           acc_f;
   logic                           acc_x;
   logic                           emit;
   logic                           y_done;
   logic signed [ACC-1:0]          rel;
   logic signed [OUT_WIDTH-1:0]    post_data;
   logic                           post_sat;

   // A transfer happens on any edge where valid && ready; valid never waits on ready,
   // and a held output only advances once the consumer takes it, freezing every stage.
   assign en        = !m_valid_y || m_ready_y;
   assign s_ready_f = !f_loaded;
   assign s_ready_x = f_loaded && en;
   assign acc_f     = s_valid_f && s_ready_f;
   assign acc_x     = s_valid_x && s_ready_x;
   assign x_nxt     = x_cnt + XW'(1);
   assign emit      = (x_nxt >= XW'(F_SIZE)) && (s_cnt == '0);
   assign y_done    = m_valid_y && m_ready_y && m_last_y;

   always_comb begin
      rel = tree[1];
      if (RELU_EN != 0 && tree[1][ACC-1]) rel = '0;
   end

   generate
      if (OUT_WIDTH >= ACC) begin : gen_wide
         always_comb begin
            post_data = OUT_WIDTH'(rel);
            post_sat  = 1'b0;
         end
      end else begin : gen_sat
         localparam logic signed [ACC-1:0] OMAX = {{(ACC-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
         localparam logic signed [ACC-1:0] OMIN = {{(ACC-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
         always_comb begin
            post_data = rel[OUT_WIDTH-1:0];
            post_sat  = 1'b0;
            if (rel > OMAX) begin
               post_data = OMAX[OUT_WIDTH-1:0];
               post_sat  = 1'b1;
            end else if (rel < OMIN) begin
               post_data = OMIN[OUT_WIDTH-1:0];
               post_sat  = 1'b1;
            end
         end
      end
   endgenerate

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         f_loaded     <= 1'b0;
         f_cnt        <= '0;
         x_cnt        <= '0;
         s_cnt        <= '0;
         tok_v        <= 1'b0;
         tok_last     <= 1'b0;
         pv           <= '0;
         pl           <= '0;
         m_valid_y    <= 1'b0;
         m_data_out_y <= '0;
         m_sat_y      <= 1'b0;
         m_last_y     <= 1'b0;
      end else begin
         if (F_RELOAD != 0 && y_done) f_loaded <= 1'b0;
         if (acc_f) begin
            if (f_cnt == LOG_F'(F_SIZE - 1)) begin
               f_cnt    <= '0;
               f_loaded <= 1'b1;
            end else begin
               f_cnt <= f_cnt + LOG_F'(1);
            end
         end
         if (acc_x) begin
            if (x_nxt == XW'(X_SIZE)) begin
               x_cnt <= '0;
               s_cnt <= '0;
            end else begin
               x_cnt <= x_nxt;
               // Stride phase only starts once the first full window exists.
               if (x_nxt >= XW'(F_SIZE))
                  s_cnt <= (s_cnt == SW'(STRIDE - 1)) ? '0 : s_cnt + SW'(1);
            end
         end
         if (en) begin
            tok_v     <= acc_x && emit;
            tok_last  <= acc_x && emit && (x_nxt == XW'(X_SIZE));
            pv        <= {pv[LOG_F-1:0], tok_v};
            pl        <= {pl[LOG_F-1:0], tok_last};
            m_valid_y <= pv[LOG_F];
            if (pv[LOG_F]) begin
               m_data_out_y <= post_data;
               m_sat_y      <= post_sat;
               m_last_y     <= pl[LOG_F];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (acc_f) f_reg[f_cnt] <= s_data_in_f;
      if (acc_x) begin
         for (int i = 0; i < F_SIZE - 1; i++) win[i] <= win[i+1];
         win[F_SIZE-1] <= s_data_in_x;
      end
      if (en) begin
         for (int i = 0; i < F_SIZE; i++)
            tree[F_SIZE+i] <= ACC'(win[i]) * ACC'(f_reg[i]);
         for (int n = 1; n < F_SIZE; n++)
            tree[n] <= tree[2*n] + tree[2*n+1];
      end
   end

endmodule

// File: tb/tb_conv_stream_sat.sv
// Bench for conv_stream_sat: a default instance and a strided/ReLU/retained-taps instance,
// driven by handshake tasks and checked against an expected-result queue per instance.
module tb_conv_stream_sat;

   localparam int XS = 128;
   localparam int FS = 32;
   localparam int OW = 16;
   localparam int N1 = 97;
   localparam int N2 = 49;

   logic clk = 1'b0;
   logic reset = 1'b1;

   logic                 a_valid_f = 1'b0, a_ready_f, a_valid_x = 1'b0, a_ready_x;
   logic signed [7:0]    a_data_f = '0, a_data_x = '0;
   logic                 a_valid_y, a_ready_y = 1'b1, a_sat, a_last;
   logic signed [OW-1:0] a_data_y;

   logic                 b_valid_f = 1'b0, b_ready_f, b_valid_x = 1'b0, b_ready_x;
   logic signed [7:0]    b_data_f = '0, b_data_x = '0;
   logic                 b_valid_y, b_ready_y = 1'b1, b_sat, b_last;
   logic signed [OW-1:0] b_data_y;

   conv_stream_sat u_a (
      .clk(clk), .reset(reset),
      .s_valid_f(a_valid_f), .s_ready_f(a_ready_f), .s_data_in_f(a_data_f),
      .s_valid_x(a_valid_x), .s_ready_x(a_ready_x), .s_data_in_x(a_data_x),
      .m_valid_y(a_valid_y), .m_ready_y(a_ready_y), .m_data_out_y(a_data_y),
      .m_sat_y(a_sat), .m_last_y(a_last)
   );

   conv_stream_sat #(.STRIDE(2), .RELU_EN(1), .F_RELOAD(0)) u_b (
      .clk(clk), .reset(reset),
      .s_valid_f(b_valid_f), .s_ready_f(b_ready_f), .s_data_in_f(b_data_f),
      .s_valid_x(b_valid_x), .s_ready_x(b_ready_x), .s_data_in_x(b_data_x),
      .m_valid_y(b_valid_y), .m_ready_y(b_ready_y), .m_data_out_y(b_data_y),
      .m_sat_y(b_sat), .m_last_y(b_last)
   );

   // {data, sat, last}
   logic [OW+1:0] exp_q[$];
   logic [OW+1:0] exp_q2[$];

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int a_lasts  = 0;
   int b_lasts  = 0;
   int xv[XS];
   int fv[FS];

   bit lat_arm   = 1'b0;
   int lat_n     = 0;
   int lat_acc   = -1;
   int lat_first = -1;

   typedef struct {
      int xval;
      int fval;
      int exp_d;
      bit exp_s;
   } vec_t;
   vec_t tbl[8];

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- checking helpers ----------------
   task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic timeout_fail(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: timed out waiting for the DUT", name);
   endtask

   function automatic logic [OW+1:0] model(input int k, input int stride, input bit relu, input bit last);
      longint s = 0;
      bit sat = 1'b0;
      logic signed [OW-1:0] d;
      for (int i = 0; i < FS; i++) s += longint'(xv[k*stride+i]) * fv[i];
      if (relu && s < 0) s = 0;
      if (s > 32767) begin
         s = 32767;
         sat = 1'b1;
      end else if (s < -32768) begin
         s = -32768;
         sat = 1'b1;
      end
      d = 16'(s);
      return {d, sat, last};
   endfunction

   // ---------------- scoreboards ----------------
   always @(negedge clk) begin : mon_a
      logic [OW+1:0] e;
      if (!reset && a_valid_y && a_ready_y) begin
         if (exp_q.size() == 0) begin
            timeout_fail("a_unexpected_result");
         end else begin
            e = exp_q.pop_front();
            check("a_data", a_data_y, $signed(e[OW+1:2]));
            check("a_sat", a_sat, e[1]);
            check("a_last", a_last, e[0]);
            if (a_last) a_lasts++;
         end
      end
   end

   always @(negedge clk) begin : mon_b
      logic [OW+1:0] e;
      if (!reset && b_valid_y && b_ready_y) begin
         if (exp_q2.size() == 0) begin
            timeout_fail("b_unexpected_result");
         end else begin
            e = exp_q2.pop_front();
            check("b_data", b_data_y, $signed(e[OW+1:2]));
            check("b_sat", b_sat, e[1]);
            check("b_last", b_last, e[0]);
            if (b_last) b_lasts++;
         end
      end
   end

   always @(negedge clk) begin
      if (lat_arm) begin
         if (a_valid_x && a_ready_x) begin
            lat_n++;
            if (lat_n == FS) lat_acc = cyc + 1;
         end
         if (a_valid_y && lat_first < 0) lat_first = cyc;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic a_push_f(input int v);
      int t = 0;
      a_valid_f = 1'b1;
      a_data_f  = 8'(v);
      @(negedge clk);
      while (!a_ready_f && t < 1000) begin @(negedge clk); t++; end
      if (!a_ready_f) timeout_fail("a_f_accept");
      @(posedge clk); #1;
   endtask

   task automatic a_push_x(input int v);
      int t = 0;
      a_valid_x = 1'b1;
      a_data_x  = 8'(v);
      @(negedge clk);
      while (!a_ready_x && t < 1000) begin @(negedge clk); t++; end
      if (!a_ready_x) timeout_fail("a_x_accept");
      @(posedge clk); #1;
   endtask

   task automatic b_push_f(input int v);
      int t = 0;
      b_valid_f = 1'b1;
      b_data_f  = 8'(v);
      @(negedge clk);
      while (!b_ready_f && t < 1000) begin @(negedge clk); t++; end
      if (!b_ready_f) timeout_fail("b_f_accept");
      @(posedge clk); #1;
   endtask

   task automatic b_push_x(input int v);
      int t = 0;
      b_valid_x = 1'b1;
      b_data_x  = 8'(v);
      @(negedge clk);
      while (!b_ready_x && t < 1000) begin @(negedge clk); t++; end
      if (!b_ready_x) timeout_fail("b_x_accept");
      @(posedge clk); #1;
   endtask

   // Loads fv, checking that X is refused until the edge after the last tap.
   task automatic a_load_f();
      for (int i = 0; i < FS - 1; i++) a_push_f(fv[i]);
      a_data_f = 8'(fv[FS-1]);
      @(negedge clk);
      check("a_x_ready_before_last_tap", a_ready_x, 0);
      check("a_f_ready_before_last_tap", a_ready_f, 1);
      @(posedge clk); #1;
      a_valid_f = 1'b0;
      check("a_x_ready_after_last_tap", a_ready_x, 1);
      check("a_f_ready_after_last_tap", a_ready_f, 0);
   endtask

   task automatic a_send_x();
      for (int i = 0; i < XS; i++) a_push_x(xv[i]);
      a_valid_x = 1'b0;
   endtask

   task automatic a_expect_model();
      for (int k = 0; k < N1; k++) exp_q.push_back(model(k, 1, 1'b0, k == N1 - 1));
   endtask

   task automatic a_drain(input string name);
      int t = 0;
      while (exp_q.size() > 0 && t < 2000) begin @(negedge clk); t++; end
      if (exp_q.size() > 0) begin
         timeout_fail(name);
         exp_q.delete();
      end
      @(posedge clk); #1;
   endtask

   task automatic check_reset_a(input string name);
      check({name, "_ready_f"}, a_ready_f, 1);
      check({name, "_ready_x"}, a_ready_x, 0);
      check({name, "_valid_y"}, a_valid_y, 0);
      check({name, "_data_y"}, a_data_y, 0);
      check({name, "_sat_y"}, a_sat, 0);
      check({name, "_last_y"}, a_last, 0);
   endtask

   // ---------------- test sequence ----------------
   initial begin : watchdog
      #600000;
      $display("FAIL watchdog: simulation time limit reached");
      n_fail++;
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      int t0;
      int t1;
      logic signed [OW-1:0] held_d;
      logic held_s;
      logic held_l;

      tbl[0] = '{1, 1, 32, 1'b0};
      tbl[1] = '{127, 127, 32767, 1'b1};
      tbl[2] = '{-128, 127, -32768, 1'b1};
      tbl[3] = '{-1, 1, -32, 1'b0};
      tbl[4] = '{3, -5, -480, 1'b0};
      tbl[5] = '{9, 127, 32767, 1'b1};
      tbl[6] = '{-128, 8, -32768, 1'b0};
      tbl[7] = '{31, 33, 32736, 1'b0};

      repeat (3) @(negedge clk);
      check_reset_a("rst_a");
      check("rst_b_ready_f", b_ready_f, 1);
      check("rst_b_valid_y", b_valid_y, 0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;

      // Constant-vector table on the default instance.
      for (int r = 0; r < 8; r++) begin
         for (int i = 0; i < FS; i++) fv[i] = tbl[r].fval;
         for (int i = 0; i < XS; i++) xv[i] = tbl[r].xval;
         a_load_f();
         for (int k = 0; k < N1; k++)
            exp_q.push_back({16'(tbl[r].exp_d), tbl[r].exp_s, k == N1 - 1});
         if (r == 0) begin
            lat_n = 0;
            lat_first = -1;
            lat_acc = -1;
            lat_arm = 1'b1;
         end
         a_send_x();
         a_drain("a_table_drain");
         lat_arm = 1'b0;
         if (r == 0) check("a_first_latency", lat_first - lat_acc, 7);
         check("a_f_ready_after_vector", a_ready_f, 1);
         check("a_last_count", a_lasts, r + 1);
      end

      // Random vector with a 10-cycle stall in mid-stream.
      for (int i = 0; i < FS; i++) fv[i] = int'($urandom_range(0, 15)) - 8;
      for (int i = 0; i < XS; i++) xv[i] = int'($urandom_range(0, 15)) - 8;
      a_load_f();
      a_expect_model();
      fork
         a_send_x();
         begin
            t0 = 0;
            while (exp_q.size() > N1 - 20 && t0 < 2000) begin @(negedge clk); t0++; end
            @(posedge clk); #1;
            t0 = 0;
            while (!a_valid_y && t0 < 100) begin @(posedge clk); #1; t0++; end
            if (!a_valid_y) timeout_fail("a_stall_setup");
            a_ready_y = 1'b0;
            held_d = a_data_y;
            held_s = a_sat;
            held_l = a_last;
            for (int c = 0; c < 10; c++) begin
               @(negedge clk);
               check("stall_valid", a_valid_y, 1);
               check("stall_data", a_data_y, held_d);
               check("stall_sat", a_sat, held_s);
               check("stall_last", a_last, held_l);
               check("stall_ready_x", a_ready_x, 0);
            end
            @(posedge clk); #1;
            a_ready_y = 1'b1;
         end
      join
      a_drain("a_stall_drain");

      // Full-range random vector, interrupted by reset after 50 samples.
      for (int i = 0; i < FS; i++) fv[i] = int'($urandom_range(0, 255)) - 128;
      for (int i = 0; i < XS; i++) xv[i] = int'($urandom_range(0, 255)) - 128;
      a_load_f();
      a_expect_model();
      for (int i = 0; i < 50; i++) a_push_x(xv[i]);
      a_valid_x = 1'b0;
      reset = 1'b1;
      exp_q.delete();
      @(negedge clk);
      check_reset_a("midrst_a");
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      for (int i = 0; i < FS; i++) fv[i] = int'($urandom_range(0, 255)) - 128;
      for (int i = 0; i < XS; i++) xv[i] = int'($urandom_range(0, 31)) - 16;
      a_load_f();
      a_expect_model();
      a_send_x();
      a_drain("a_after_reset_drain");
      check("a_f_ready_after_reset_vector", a_ready_f, 1);

      // Strided, rectified, retained-taps instance: two back-to-back vectors.
      b_lasts = 0;
      for (int i = 0; i < FS; i++) b_push_f(1);
      b_valid_f = 1'b0;
      check("b_x_ready_after_taps", b_ready_x, 1);
      for (int k = 0; k < N2; k++)
         exp_q2.push_back({16'(64 * k + 496), 1'b0, k == N2 - 1});
      for (int k = 0; k < N2; k++)
         exp_q2.push_back({16'(0), 1'b0, k == N2 - 1});
      t0 = cyc;
      for (int i = 0; i < XS; i++) b_push_x(i);
      for (int i = 0; i < XS; i++) b_push_x(-128);
      b_valid_x = 1'b0;
      t1 = cyc;
      check("b_no_gap_cycles", t1 - t0, 2 * XS);
      check("b_f_ready_retained", b_ready_f, 0);
      t0 = 0;
      while (exp_q2.size() > 0 && t0 < 2000) begin @(negedge clk); t0++; end
      if (exp_q2.size() > 0) timeout_fail("b_drain");
      @(posedge clk); #1;
      check("b_last_count", b_lasts, 2);
      check("b_f_ready_after_drain", b_ready_f, 0);
      check("b_x_ready_after_drain", b_ready_x, 1);

      repeat (5) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/conv_stream_sat.md
# conv_stream_sat

Streaming, fully parametrised 1-D convolution engine. It accepts one filter vector F (F_SIZE taps) and one input vector X (X_SIZE samples) over valid/ready handshakes. It computes every strided window dot product in a stall-able multiply/adder-tree pipeline and emits each result rectified (optional) and saturated to OUT_WIDTH, with per-result saturation and end-of-vector flags. It sits where the fixed 128/32 convolver sits and is the successor to it, adding stride, ReLU, saturation, coefficient retention and drain/next-vector overlap.

## Interface
- DATA_WIDTH_X, 8, signed X sample width
- DATA_WIDTH_F, 8, signed F tap width
- X_SIZE, 128, samples per X vector
- F_SIZE, 32, taps; power of two, ≥2, ≤X_SIZE
- STRIDE, 1, window step; (X_SIZE−F_SIZE) % STRIDE == 0
- OUT_WIDTH, 16, signed output width
- RELU_EN, 0, 1 = clamp negative sums to 0
- F_RELOAD, 1, 1 = new F required per vector; 0 = taps retained

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high; one clock domain
- s_valid_f / s_ready_f  in/out  1  F handshake
- s_data_in_f  in  DATA_WIDTH_F  tap, index 0 first
- s_valid_x / s_ready_x  in/out  1  X handshake
- s_data_in_x  in  DATA_WIDTH_X  sample, index 0 first
- m_valid_y / m_ready_y  out/in  1  Y handshake
- m_data_out_y  out  OUT_WIDTH  result
- m_sat_y  out  1  result was clipped
- m_last_y  out  1  last result of vector

## Operation
- Definitions: LOG_F = log2(F_SIZE). ACC = DATA_WIDTH_X+DATA_WIDTH_F+LOG_F. N_OUT = (X_SIZE−F_SIZE)/STRIDE+1.
- Result k = Σ_i x[k·STRIDE+i]·f[i], exact in ACC bits.
- F load: tap counter 0..F_SIZE−1. s_ready_f = !f_loaded. f_loaded sets on the edge accepting tap F_SIZE−1.
- f_loaded clears on the m_last_y handshake when F_RELOAD=1. It is never cleared when F_RELOAD=0, except by reset.
- Pipeline enable: en = !m_valid_y || m_ready_y.
- X intake: s_ready_x = f_loaded && en.
  - Each accepted sample shifts into an F_SIZE-deep window. x_cnt increments and wraps to 0 after sample X_SIZE−1.
  - The next vector's samples are accepted immediately, overlapping the drain of the previous vector.
- Token insertion: on an accept making x_cnt+1 ≥ F_SIZE with (x_cnt+1−F_SIZE) % STRIDE == 0, a valid token enters stage 0; otherwise a bubble enters.
  - A token marks last when x_cnt+1 == X_SIZE.
- Stages, all advancing only when en:
  - stage 1: F_SIZE product registers, signed DX+DF bits
  - stages 2..LOG_F+1: adder-tree levels, each sign-extended one bit
  - stage LOG_F+2: post-processing, then the output register
- Post-processing:
  - If RELU_EN and sum < 0, the sum becomes 0.
  - Saturate to [−2^(OUT_WIDTH−1), 2^(OUT_WIDTH−1)−1]. m_sat_y = 1 iff clipped.
  - If OUT_WIDTH ≥ ACC, sign-extend; m_sat_y is always 0.
- A bubble arriving at the output register clears m_valid_y (only when en).

## Timing
- Reset values: s_ready_f=1, s_ready_x=0, m_valid_y=0, m_data_out_y=0, m_sat_y=0, m_last_y=0. All counters, valid bits and f_loaded are 0.
- Reset asserted mid-vector discards all taps, samples and tokens. After release the block behaves as fresh.
- Latency: a token accepted on edge E presents m_valid_y after edge E+LOG_F+2 (7 for F_SIZE=32) if no stall occurs.
- First s_ready_x=1 occurs in the cycle after the edge that accepts the last tap. X is never accepted on the same edge as the last tap.
- Stall (m_valid_y && !m_ready_y): the entire pipeline freezes and s_ready_x=0. m_data_out_y, m_sat_y and m_last_y are held stable.
- Throughput: one sample per cycle with no stall. Results arrive every STRIDE cycles.
- F_RELOAD=1: s_ready_f rises in the cycle after the m_last_y handshake. X for the next vector waits for the new F.
- Valid and ready may be held high continuously. No combinational path exists from m_ready_y to m_valid_y.

## Test plan
- Defaults, all x=1, f=1: exactly 97 results, each 32. m_sat_y=0. m_last_y only on the 97th. First m_valid_y appears 7 cycles after the 32nd x is accepted.
- x=127, f=127, OUT_WIDTH=16: sum 516128, so every output is 32767 with m_sat_y=1. With x=−128 instead: every output is −32768 with m_sat_y=1. With RELU_EN=1 and x=−128: output 0, m_sat_y=0.
- STRIDE=2, x[n]=n, f=1: 49 results. Result k = Σ(2k..2k+31) = 64k+496, e.g. results 496, 560, …
- Backpressure: drop m_ready_y for 10 cycles mid-stream. Outputs are stable and s_ready_x=0 throughout. No result is lost or duplicated (order checked against a golden model).
- F_RELOAD=0: stream two X vectors back-to-back. The second is accepted with no gap and no F traffic. Both produce 97 correct results, and m_last_y pulses twice.
- Assert reset after 50 samples. All outputs return to reset values. A fresh F and X then give fully correct results.
